// File: rtl/mpcache_pkg.sv
// mpcache_pkg: shared defaults and the FSM state type for the multiport cache read-side logic.
package mpcache_pkg;

    localparam int unsigned NUM_PORTS_DEF  = 16;
    localparam int unsigned DATA_WIDTH_DEF = 128;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } rd_pkt_mux_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts at ptr and wraps around.
module rr_arbiter #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        logic [W-1:0] p;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            p = W'((32'(ptr) + k) % N);
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = p;
            end
        end
    end

endmodule

// File: rtl/rd_pkt_mux.sv
// rd_pkt_mux: packet-locked N:1 read-stream mux feeding one registered output stage.
// Define RD_PKT_MUX_RR_EN for round-robin arbitration; otherwise i_sel picks the port.
module rd_pkt_mux
    import mpcache_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SEL_W      = $clog2(NUM_PORTS)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_en,
    input  logic [SEL_W-1:0]                     i_sel,
    input  logic [NUM_PORTS-1:0]                 i_rd_vld,
    input  logic [NUM_PORTS-1:0]                 i_rd_sop,
    input  logic [NUM_PORTS-1:0]                 i_rd_eop,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_rd_data,
    output logic [NUM_PORTS-1:0]                 o_rd_rdy,
    output logic                                 o_vld,
    output logic                                 o_sop,
    output logic                                 o_eop,
    output logic [DATA_WIDTH-1:0]                o_data,
    input  logic                                 i_rdy,
    output logic [SEL_W-1:0]                     o_grant,
    output logic                                 o_busy,
    output logic                                 o_err
);

    localparam int unsigned    CNT_W   = SEL_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rd_pkt_mux_state_e     state;
    rd_pkt_mux_state_e     state_nxt;
    logic [NUM_PORTS-1:0]  req;
    logic                  req_win;
    logic [SEL_W-1:0]      win_idx;
    logic                  out_free;
    logic                  accept;
    logic                  grant_take;
    logic                  cur_vld;
    logic                  cur_sop;
    logic                  cur_eop;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [CNT_W-1:0]      beat_cnt;

    assign req      = i_rd_vld & i_rd_sop;
    assign cur_vld  = i_rd_vld[o_grant];
    assign cur_sop  = i_rd_sop[o_grant];
    assign cur_eop  = i_rd_eop[o_grant];
    assign cur_data = i_rd_data[o_grant];
    assign out_free = !o_vld || i_rdy;

`ifdef RD_PKT_MUX_RR_EN
    logic [SEL_W-1:0]     rr_ptr;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic                 arb_any;

    rr_arbiter #(
        .N (NUM_PORTS),
        .W (SEL_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (win_idx),
        .any (arb_any)
    );

    assign req_win = arb_any && ((arb_gnt & req) != '0);

    // Priority moves past the owner once its packet has fully gone through.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= '0;
        end else if (accept && cur_eop) begin
            rr_ptr <= (32'(o_grant) == NUM_PORTS - 1) ? '0 : o_grant + SEL_W'(1);
        end
    end
`else
    assign win_idx = i_sel;
    assign req_win = (32'(i_sel) < NUM_PORTS) && req[i_sel];
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en && req_win) state_nxt = LOCK;
            LOCK:    if (accept && cur_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready only ever depends on state, grant and output occupancy, never on input valid.
    always_comb begin
        o_rd_rdy = '0;
        accept   = 1'b0;
        if (state == LOCK) begin
            o_rd_rdy[o_grant] = out_free;
            accept            = cur_vld && out_free;
        end
    end

    assign grant_take = (state == IDLE) && (state_nxt == LOCK);

    // Grant, busy, sticky error and the per-packet beat count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant  <= '0;
            o_busy   <= 1'b0;
            o_err    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            o_busy <= (state_nxt == LOCK);
            if (grant_take) begin
                o_grant <= win_idx;
            end
            if (accept && cur_sop && (beat_cnt != '0)) begin
                o_err <= 1'b1;
            end
            if (grant_take) begin
                beat_cnt <= '0;
            end else if (accept) begin
                if (cur_eop) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != CNT_MAX) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output stage: a load on accept also covers a same-cycle drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vld  <= 1'b0;
            o_sop  <= 1'b0;
            o_eop  <= 1'b0;
            o_data <= '0;
        end else if (accept) begin
            o_vld  <= 1'b1;
            o_sop  <= cur_sop;
            o_eop  <= cur_eop;
            o_data <= cur_data;
        end else if (o_vld && i_rdy) begin
            o_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rd_pkt_mux.sv
// tb_rd_pkt_mux: directed and randomized checks of rd_pkt_mux against per-port packet scoreboards.
// Builds with or without RD_PKT_MUX_RR_EN; the arbitration-order section follows the macro.
module tb_rd_pkt_mux;

    localparam int NP = 16;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef RD_PKT_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_en;
    logic [SW-1:0]          i_sel;
    logic [NP-1:0]          i_rd_vld;
    logic [NP-1:0]          i_rd_sop;
    logic [NP-1:0]          i_rd_eop;
    logic [NP-1:0][DW-1:0]  i_rd_data;
    logic [NP-1:0]          o_rd_rdy;
    logic                   o_vld;
    logic                   o_sop;
    logic                   o_eop;
    logic [DW-1:0]          o_data;
    logic                   i_rdy;
    logic [SW-1:0]          o_grant;
    logic                   o_busy;
    logic                   o_err;

    rd_pkt_mux #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_sel     (i_sel),
        .i_rd_vld  (i_rd_vld),
        .i_rd_sop  (i_rd_sop),
        .i_rd_eop  (i_rd_eop),
        .i_rd_data (i_rd_data),
        .o_rd_rdy  (o_rd_rdy),
        .o_vld     (o_vld),
        .o_sop     (o_sop),
        .o_eop     (o_eop),
        .o_data    (o_data),
        .i_rdy     (i_rdy),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int            tests = 0;
    int            fails = 0;
    beat_t         pq[NP][$];
    beat_t         eq[NP][$];
    int            order_q[$];
    int            gap_q[$];
    int            cyc;
    int            last_deliv;
    int            cur_port;
    int            vld_pct;
    int            rdy_pct;
    logic [NP-1:0] allow;
    logic          prev_stall;
    logic [DW+1:0] prev_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_left();
        int n = 0;
        for (int p = 0; p < NP; p++) n += eq[p].size();
        return n;
    endfunction

    // Queue one packet on port p; data carries the port id in its top byte.
    task automatic gen_pkt(input int p, input int len, input bit expect_out, input int sop_at = 0);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(p), 24'($urandom)};
            b.sop  = (i == 0) || (sop_at > 0 && i == sop_at);
            b.eop  = (i == len - 1);
            pq[p].push_back(b);
            if (expect_out) eq[p].push_back(b);
        end
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            eq[p].delete();
        end
        i_rd_vld = '0;
    endtask

    task automatic do_reset();
        flush();
        i_rst = 1'b1;
        i_rdy = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_sop_eop", {o_sop, o_eop}, 0);
        chk("rst_data", o_data, 0);
        chk("rst_rdy", o_rd_rdy, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        i_rst      = 1'b0;
        prev_stall = 1'b0;
        cur_port   = -1;
    endtask

    // One clock: drive sources, check this cycle's outputs, score deliveries, advance sources.
    task automatic step();
        logic [NP-1:0] acc;
        beat_t         e;
        int            p;
        for (int q = 0; q < NP; q++) begin
            if (pq[q].size() > 0 && $urandom_range(0, 99) < vld_pct) begin
                i_rd_vld[q]  = 1'b1;
                i_rd_sop[q]  = pq[q][0].sop;
                i_rd_eop[q]  = pq[q][0].eop;
                i_rd_data[q] = pq[q][0].data;
            end else begin
                i_rd_vld[q]  = 1'b0;
                i_rd_sop[q]  = 1'($urandom);
                i_rd_eop[q]  = 1'($urandom);
                i_rd_data[q] = $urandom;
            end
        end
        if (rdy_pct < 0) i_rdy = ~i_rdy;
        else             i_rdy = ($urandom_range(0, 99) < rdy_pct);
        #1;
        chk("rdy_onehot", $onehot0(o_rd_rdy), 1);
        chk("rdy_port", o_rd_rdy & ~allow, 0);
        if (!o_busy) chk("rdy_idle", o_rd_rdy, 0);
        if (o_vld && !i_rdy) chk("rdy_full", o_rd_rdy, 0);
        if (prev_stall) begin
            chk("stall_vld", o_vld, 1);
            chk("stall_beat", {o_sop, o_eop, o_data}, prev_beat);
        end
        if (o_vld && i_rdy) begin
            p = int'(o_data[DW-1 -: 8]);
            if (cur_port >= 0) chk("interleave", p, cur_port);
            chk("beat_expected", (p < NP) && (eq[p].size() != 0), 1);
            if (p < NP && eq[p].size() != 0) begin
                e = eq[p].pop_front();
                chk("beat", {o_sop, o_eop, o_data}, e);
                if (e.sop && !(cur_port == p)) order_q.push_back(p);
                cur_port = e.eop ? -1 : p;
                gap_q.push_back(cyc - last_deliv);
                last_deliv = cyc;
            end
        end
        prev_stall = o_vld && !i_rdy;
        prev_beat  = {o_sop, o_eop, o_data};
        acc = i_rd_vld & o_rd_rdy;
        for (int q = 0; q < NP; q++) begin
            if (acc[q] && pq[q].size() > 0) void'(pq[q].pop_front());
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (exp_left() > 0 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_drain"}, exp_left(), 0);
    endtask

    task automatic wait_busy(input string tag);
        for (int k = 0; k < 10 && !o_busy; k++) step();
        chk({tag, "_busy"}, o_busy, 1);
    endtask

    initial begin
        int sel;
        int npk;
        int op;
        logic [DW-1:0] d;

        cyc = 0; last_deliv = 0; cur_port = -1; prev_stall = 1'b0; prev_beat = '0;
        i_en = 1'b1; i_sel = '0; i_rdy = 1'b1; i_rst = 1'b1;
        i_rd_vld = '0; i_rd_sop = '0; i_rd_eop = '0; i_rd_data = '0;
        vld_pct = 100; rdy_pct = 100; allow = '0;
        do_reset();

        // Latency: request at T, grant/busy at T+1, output beat at T+2.
        i_sel = SW'(3);
        d = $urandom;
        i_rd_vld[3] = 1'b1; i_rd_sop[3] = 1'b1; i_rd_eop[3] = 1'b1; i_rd_data[3] = d;
        #1;
        chk("lat_t0_busy", o_busy, 0);
        chk("lat_t0_rdy", o_rd_rdy, 0);
        @(posedge i_clk); @(negedge i_clk); #1;
        chk("lat_t1_busy", o_busy, 1);
        chk("lat_t1_grant", o_grant, 3);
        chk("lat_t1_rdy", o_rd_rdy, 16'h0008);
        chk("lat_t1_vld", o_vld, 0);
        @(posedge i_clk); @(negedge i_clk);
        i_rd_vld = '0;
        #1;
        chk("lat_t2_beat", {o_vld, o_sop, o_eop, o_data}, {3'b111, d});
        chk("lat_t2_busy", o_busy, 0);
        chk("lat_t2_rdy", o_rd_rdy, 0);
        @(posedge i_clk); @(negedge i_clk); #1;
        chk("lat_t3_vld", o_vld, 0);

`ifdef RD_PKT_MUX_RR_EN
        // Round-robin fairness: 0, 5, 15 repeat with one bubble between packets.
        do_reset();
        allow = 16'h8021; vld_pct = 100; rdy_pct = 100;
        for (int r = 0; r < 3; r++) begin
            gen_pkt(0, 4, 1'b1); gen_pkt(5, 4, 1'b1); gen_pkt(15, 4, 1'b1);
        end
        order_q.delete(); gap_q.delete();
        drain("rr", 200);
        chk("rr_npkt", order_q.size(), 9);
        for (int i = 0; i < order_q.size(); i++)
            chk("rr_order", order_q[i], (i % 3 == 0) ? 0 : (i % 3 == 1) ? 5 : 15);
        for (int i = 1; i < gap_q.size(); i++)
            chk("rr_gap", gap_q[i], (i % 4 == 0) ? 2 : 1);
`else
        // Fixed select: port 7 wins over 3 and finishes even after i_sel moves to 3.
        i_sel = SW'(7);
        allow = 16'h0088; vld_pct = 100; rdy_pct = 100;
        gen_pkt(7, 4, 1'b1);
        gen_pkt(3, 3, 1'b1);
        order_q.delete();
        wait_busy("fix");
        chk("fix_grant", o_grant, 7);
        i_sel = SW'(3);
        drain("fix", 100);
        chk("fix_npkt", order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk("fix_first", order_q[0], 7);
            chk("fix_second", order_q[1], 3);
        end
`endif

        // Backpressure: i_rdy toggles every cycle through an 8-beat packet.
        do_reset();
        i_sel = SW'(6); allow = RR ? {NP{1'b1}} : 16'h0040;
        vld_pct = 100; rdy_pct = -1;
        gen_pkt(6, 8, 1'b1);
        drain("bp", 100);

        // Back-to-back single-beat packets on port 1: one bubble between them.
        i_sel = SW'(1); allow = RR ? {NP{1'b1}} : 16'h0002;
        vld_pct = 100; rdy_pct = 100;
        gen_pkt(1, 1, 1'b1); gen_pkt(1, 1, 1'b1);
        gap_q.delete();
        drain("single", 50);
        chk("single_n", gap_q.size(), 2);
        if (gap_q.size() == 2) chk("single_gap", gap_q[1], 2);

        // Randomized packets, valids and downstream ready.
        for (int r = 0; r < 20; r++) begin
            sel   = $urandom_range(0, NP - 1);
            i_sel = SW'(sel);
            allow = RR ? {NP{1'b1}} : (NP'(1) << sel);
            vld_pct = $urandom_range(40, 100);
            rdy_pct = $urandom_range(30, 100);
            npk = $urandom_range(1, 3);
            for (int k = 0; k < npk; k++) gen_pkt(sel, $urandom_range(1, 6), 1'b1);
            for (int k = 0; k < 2; k++) begin
                op = $urandom_range(0, NP - 1);
                gen_pkt(op, $urandom_range(1, 4), RR || (op == sel));
            end
            drain("rand", 600);
            chk("rand_err", o_err, 0);
            flush();
        end

        // Protocol error: sop on beat 2 is forwarded and o_err sticks.
        i_sel = SW'(8); allow = RR ? {NP{1'b1}} : 16'h0100;
        vld_pct = 100; rdy_pct = 100;
        chk("err_before", o_err, 0);
        gen_pkt(8, 4, 1'b1, 1);
        drain("err", 50);
        chk("err_set", o_err, 1);
        gen_pkt(8, 3, 1'b1);
        drain("err2", 50);
        chk("err_sticky", o_err, 1);

        // Enable dropped mid-packet: packet completes, no further grants.
        do_reset();
        i_sel = SW'(4); allow = RR ? 16'h0210 : 16'h0010;
        vld_pct = 100; rdy_pct = 100;
        gen_pkt(4, 6, 1'b1);
        gen_pkt(4, 3, 1'b0);
        gen_pkt(9, 3, 1'b0);
        wait_busy("en");
        i_en = 1'b0;
        drain("en", 50);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("en_no_grant", o_busy, 0);
        end
        chk("en_port4_held", pq[4].size(), 3);
        chk("en_port9_held", pq[9].size(), 3);
        i_en = 1'b1;

        // Reset during beat 3 of 5, then a fresh packet on port 2 goes through intact.
        do_reset();
        i_sel = SW'(2); allow = RR ? {NP{1'b1}} : 16'h0004;
        vld_pct = 100; rdy_pct = 100;
        gen_pkt(2, 5, 1'b1);
        for (int k = 0; k < 20 && pq[2].size() > 2; k++) step();
        chk("rstmid_progress", pq[2].size(), 2);
        do_reset();
        order_q.delete();
        gen_pkt(2, 5, 1'b1);
        drain("rstmid", 50);
        chk("rstmid_npkt", order_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
